alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter around one shared 8x8 ALU
// Package holds the opcode encoding shared with requesters.
package alu_pkg;
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_XOR = 2'd3
   } alu_op_t;
endpackage

module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [7:0]       req_a0,
   input  logic [7:0]       req_b0,
   input  logic [7:0]       req_a1,
   input  logic [7:0]       req_b1,
   input  logic [1:0]       req_op0,
   input  logic [1:0]       req_op1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [15:0]      rsp_result,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   import alu_pkg::*;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nxt;
   logic        last_grant;
   logic        sel;
   logic        accept;
   logic [7:0]  a_q, b_q;
   logic [1:0]  op_q;
   logic [15:0] alu_out;

   // On a tie the requester that did not win last time goes next.
   always_comb begin
      sel = 1'b0;
      case (req_valid)
         2'b10:   sel = 1'b1;
         2'b11:   sel = ~last_grant;
         default: sel = 1'b0;
      endcase
   end

   // rst_n gates ready so nothing is offered while reset is held.
   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (rst_n && req_valid[sel]) begin
               req_ready[sel] = 1'b1;
               state_nxt      = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = |(req_valid & req_ready);

   always_comb begin
      alu_out = 16'd0;
      case (alu_op_t'(op_q))
         OP_ADD: alu_out = {8'd0, a_q} + {8'd0, b_q};
         OP_SUB: alu_out = {8'd0, a_q} - {8'd0, b_q};
         OP_MUL: alu_out = {8'd0, a_q} * {8'd0, b_q};
         OP_XOR: alu_out = {8'd0, a_q ^ b_q};
         default: alu_out = 16'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         a_q        <= 8'd0;
         b_q        <= 8'd0;
         op_q       <= 2'd0;
         rsp_id     <= 1'b0;
         rsp_result <= 16'd0;
         op_count   <= '0;
      end else begin
         if (accept) begin
            a_q        <= sel ? req_a1  : req_a0;
            b_q        <= sel ? req_b1  : req_b0;
            op_q       <= sel ? req_op1 : req_op0;
            rsp_id     <= sel;
            last_grant <= sel;
         end
         if (state == EXEC) rsp_result <= alu_out;
         if (state == RESP && rsp_ready) op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
endmodule
